// File: rtl/sm_imem_loader_if.sv
// Loader bundle: byte-stream handshake and start request in; instruction-RAM write port and load status out.
// master = byte source / controller side, slave = loader side.
interface sm_imem_loader_if;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        we;
   logic [31:0] wa;
   logic [31:0] wd;
   logic        cpu_hold;
   logic        done;
   logic        err;
   logic [15:0] words;

   modport master (
      output start, in_valid, in_data,
      input  in_ready, we, wa, wd, cpu_hold, done, err, words
   );

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, we, wa, wd, cpu_hold, done, err, words
   );
endinterface

// File: rtl/sm_imem_loader.sv
// Byte-stream instruction loader: length-prefixed LE words, RAM write one cycle after each word's 4th byte.
// in_ready is low in IDLE/WRITE/FIN (max 4 bytes per 5 cycles); LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module sm_imem_loader #(
   parameter int SIZE = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   sm_imem_loader_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      WRITE,
      DRAIN,
      FIN
`ifdef LOADER_CHECKSUM_EN
      , CSUM
`endif
   } state_t;

`ifdef LOADER_CHECKSUM_EN
   localparam state_t LAST = CSUM;
`else
   localparam state_t LAST = FIN;
`endif

   localparam logic [16:0] SIZE_W = 17'(SIZE);

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d, len_n;
   logic [1:0]  bc_q, bc_d;
   logic [23:0] asm_q, asm_d;
   logic [17:0] drain_q, drain_d;
   logic [15:0] words_q, words_d;
   logic        err_q, err_d;
   logic        in_ready_q, in_ready_d;
   logic        cpu_hold_q, cpu_hold_d;
   logic        done_q, done_d;
   logic        we_q, we_d;
   logic [31:0] wa_q, wa_d;
   logic [31:0] wd_q, wd_d;
   logic        fire;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      bc_d    = bc_q;
      asm_d   = asm_q;
      drain_d = drain_q;
      words_d = words_q;
      err_d   = err_q;
      wa_d    = wa_q;
      wd_d    = wd_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      len_n   = {bus.in_data, len_q[7:0]};
      fire    = in_ready_q & bus.in_valid;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = LEN0;
               err_d   = 1'b0;
               words_d = 16'd0;
               bc_d    = 2'd0;
`ifdef LOADER_CHECKSUM_EN
               csum_d  = 8'd0;
`endif
            end
         end
         LEN0: begin
            if (fire) begin
               len_d[7:0] = bus.in_data;
               state_d    = LEN1;
            end
         end
         LEN1: begin
            if (fire) begin
               len_d[15:8] = bus.in_data;
               if (len_n == 16'd0) begin
                  state_d = LAST;
               end else if ({1'b0, len_n} > SIZE_W) begin
                  // Oversized frame: swallow the payload so the source stays in sync.
                  err_d   = 1'b1;
                  drain_d = {len_n, 2'b00};
                  state_d = DRAIN;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (fire) begin
`ifdef LOADER_CHECKSUM_EN
               csum_d = csum_q ^ bus.in_data;
`endif
               bc_d = bc_q + 2'd1;
               case (bc_q)
                  2'd0:    asm_d[7:0]   = bus.in_data;
                  2'd1:    asm_d[15:8]  = bus.in_data;
                  2'd2:    asm_d[23:16] = bus.in_data;
                  default: begin
                     wa_d    = {16'd0, words_q};
                     wd_d    = {bus.in_data, asm_q};
                     state_d = WRITE;
                  end
               endcase
            end
         end
         WRITE: begin
            words_d = words_q + 16'd1;
            state_d = (words_d == len_q) ? LAST : DATA;
         end
         DRAIN: begin
            if (fire) begin
`ifdef LOADER_CHECKSUM_EN
               csum_d = csum_q ^ bus.in_data;
`endif
               drain_d = drain_q - 18'd1;
               if (drain_q == 18'd1) begin
                  state_d = LAST;
               end
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CSUM: begin
            if (fire) begin
               if (bus.in_data != csum_q) begin
                  err_d = 1'b1;
               end
               state_d = FIN;
            end
         end
`endif
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Handshake and status outputs are registered from the next state.
      in_ready_d = (state_d == LEN0) || (state_d == LEN1) ||
                   (state_d == DATA) || (state_d == DRAIN);
`ifdef LOADER_CHECKSUM_EN
      in_ready_d = in_ready_d || (state_d == CSUM);
`endif
      cpu_hold_d = (state_d != IDLE) && (state_d != FIN);
      done_d     = (state_d == FIN);
      we_d       = (state_d == WRITE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         len_q      <= 16'd0;
         bc_q       <= 2'd0;
         asm_q      <= 24'd0;
         drain_q    <= 18'd0;
         words_q    <= 16'd0;
         err_q      <= 1'b0;
         in_ready_q <= 1'b0;
         cpu_hold_q <= 1'b0;
         done_q     <= 1'b0;
         we_q       <= 1'b0;
         wa_q       <= 32'd0;
         wd_q       <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
         csum_q     <= 8'd0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         bc_q       <= bc_d;
         asm_q      <= asm_d;
         drain_q    <= drain_d;
         words_q    <= words_d;
         err_q      <= err_d;
         in_ready_q <= in_ready_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
         we_q       <= we_d;
         wa_q       <= wa_d;
         wd_q       <= wd_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign bus.in_ready = in_ready_q;
   assign bus.we       = we_q;
   assign bus.wa       = wa_q;
   assign bus.wd       = wd_q;
   assign bus.cpu_hold = cpu_hold_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.words    = words_q;

endmodule

// File: tb/tb_sm_imem_loader.sv
// Self-checking bench for sm_imem_loader: vector table, reset-mid-load sequence, random frames vs. a frame-level model.
module tb_sm_imem_loader;
   localparam int SIZE   = 64;
   localparam int BUDGET = 2000;
`ifdef LOADER_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   typedef logic [7:0]  byte_q_t[$];
   typedef logic [31:0] word_q_t[$];

   typedef struct {
      int          n;
      int          mode;
      logic [31:0] w0;
      logic [31:0] w1;
      bit          bad_cs;
      logic        exp_err;
      int          exp_words;
      int          exp_done;
   } vec_t;

   typedef struct {
      int          done_cnt;
      int          done_cyc;
      int          viol;
      logic        err;
      logic [15:0] words;
      logic        err_after;
   } res_t;

   logic clk;
   logic rst_n;
   int   total;
   int   nbad;

   logic [31:0] wr_wa[$];
   logic [31:0] wr_wd[$];
   logic [31:0] mem[SIZE];

   sm_imem_loader_if bus ();

   sm_imem_loader #(.SIZE(SIZE)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   function automatic word_q_t gen_words(input int n, input logic [31:0] w0, input logic [31:0] w1);
      word_q_t q;
      for (int i = 0; i < n; i++) begin
         if (i == 0)      q.push_back(w0);
         else if (i == 1) q.push_back(w1);
         else             q.push_back(w0 ^ (32'(i) * 32'h9E3779B1));
      end
      return q;
   endfunction

   // Header, little-endian payload, then (with the checksum build) the XOR of every payload byte.
   function automatic byte_q_t build_frame(input int n, input word_q_t w, input bit bad_cs);
      byte_q_t     b;
      logic [7:0]  x;
      logic [15:0] n16;
      logic [31:0] cur;
      x   = 8'd0;
      n16 = 16'(n);
      b.push_back(n16[7:0]);
      b.push_back(n16[15:8]);
      for (int i = 0; i < w.size(); i++) begin
         cur = w[i];
         for (int k = 0; k < 4; k++) begin
            b.push_back(cur[8*k +: 8]);
            x = x ^ cur[8*k +: 8];
         end
      end
      if (CS == 1) b.push_back(bad_cs ? (x ^ 8'h01) : x);
      return b;
   endfunction

   // mode 0: byte always offered, 1: every other cycle, 2: random gaps plus stray start pulses.
   task automatic run_frame(input byte_q_t fb, input int mode, output res_t r);
      int idx;
      int cyc;
      bit take;
      bit fin;
      r.done_cnt  = 0;
      r.done_cyc  = -1;
      r.viol      = 0;
      r.err       = 1'b0;
      r.words     = 16'd0;
      r.err_after = 1'b0;
      wr_wa.delete();
      wr_wd.delete();
      @(negedge clk);
      bus.start    = 1'b1;
      bus.in_valid = 1'b0;
      idx  = 0;
      cyc  = 0;
      take = 1'b0;
      fin  = 1'b0;
      while (!fin) begin
         @(negedge clk);
         cyc++;
         bus.start = 1'b0;
         if (take) idx++;
         if (bus.we) begin
            wr_wa.push_back(bus.wa);
            wr_wd.push_back(bus.wd);
            if (bus.in_ready) r.viol++;
            if (bus.wa < 32'(SIZE)) mem[bus.wa[5:0]] = bus.wd;
            else                    r.viol++;
         end
         if (bus.done) begin
            r.done_cnt++;
            r.done_cyc = cyc;
            r.err      = bus.err;
            r.words    = bus.words;
            if (bus.cpu_hold) r.viol++;
         end else if (r.done_cnt == 0 && !bus.cpu_hold) begin
            r.viol++;
         end
         if (r.done_cnt > 0 && cyc >= r.done_cyc + 2) begin
            r.err_after = bus.err;
            fin = 1'b1;
         end
         if (cyc > BUDGET) begin
            total++;
            nbad++;
            $display("FAIL frame_timeout: got %0d cycles want done within %0d", cyc, BUDGET);
            fin = 1'b1;
         end
         case (mode)
            0:       bus.in_valid = (idx < fb.size());
            1:       bus.in_valid = (idx < fb.size()) && (cyc % 2 == 0);
            default: bus.in_valid = (idx < fb.size()) && ($urandom_range(0, 2) != 0);
         endcase
         bus.in_data = bus.in_valid ? fb[idx] : 8'($urandom);
         if (mode == 2 && r.done_cnt == 0 && $urandom_range(0, 9) == 0) bus.start = 1'b1;
         take = bus.in_valid && bus.in_ready;
      end
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
   endtask

   task automatic check_frame(input string tag, input res_t r, input word_q_t exp_w,
                              input logic exp_err, input int exp_words, input int exp_done);
      check({tag, ".done_cnt"}, 32'(r.done_cnt), 32'd1);
      check({tag, ".err"}, 32'(r.err), 32'(exp_err));
      check({tag, ".err_hold"}, 32'(r.err_after), 32'(exp_err));
      check({tag, ".words"}, 32'(r.words), 32'(exp_words));
      check({tag, ".viol"}, 32'(r.viol), 32'd0);
      check({tag, ".nwr"}, 32'(wr_wa.size()), 32'(exp_w.size()));
      for (int i = 0; i < exp_w.size() && i < wr_wa.size(); i++) begin
         check($sformatf("%s.wa%0d", tag, i), wr_wa[i], 32'(i));
         check($sformatf("%s.wd%0d", tag, i), wr_wd[i], exp_w[i]);
      end
      if (exp_done >= 0) check({tag, ".done_cyc"}, 32'(r.done_cyc), 32'(exp_done));
   endtask

   task automatic push_byte(input logic [7:0] b);
      int guard;
      guard        = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (!bus.in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (guard >= 50) begin
         total++;
         nbad++;
         $display("FAIL push_timeout: got in_ready=0 for %0d cycles want 1", guard);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, ".we"}, 32'(bus.we), 32'd0);
      check({tag, ".wa"}, bus.wa, 32'd0);
      check({tag, ".wd"}, bus.wd, 32'd0);
      check({tag, ".cpu_hold"}, 32'(bus.cpu_hold), 32'd0);
      check({tag, ".done"}, 32'(bus.done), 32'd0);
      check({tag, ".err"}, 32'(bus.err), 32'd0);
      check({tag, ".words"}, 32'(bus.words), 32'd0);
   endtask

   vec_t tbl[7];

   initial begin
      byte_q_t fb;
      word_q_t w;
      res_t    r;

      tbl[0] = '{2,  0, 32'h00000013, 32'h00100093, 1'b0, 1'b0,      2,  13 + CS};
      tbl[1] = '{2,  1, 32'h00000013, 32'h00100093, 1'b0, 1'b0,      2,  -1};
      tbl[2] = '{0,  0, 32'h0,        32'h0,        1'b0, 1'b0,      0,  3 + CS};
      tbl[3] = '{65, 0, 32'hDEADBEEF, 32'h0BADF00D, 1'b0, 1'b1,      0,  263 + CS};
      tbl[4] = '{64, 0, 32'hCAFE1234, 32'h5A5AA5A5, 1'b0, 1'b0,      64, 323 + CS};
      tbl[5] = '{1,  0, 32'h08040201, 32'h0,        1'b0, 1'b0,      1,  8 + CS};
      tbl[6] = '{1,  0, 32'h08040201, 32'h0,        1'b1, 1'(CS),    1,  8 + CS};

      total = 0;
      nbad  = 0;
      clk   = 1'b0;
      rst_n = 1'b0;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'd0;
      for (int i = 0; i < SIZE; i++) mem[i] = 32'd0;

      #12;
      check_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         w = gen_words(tbl[i].n, tbl[i].w0, tbl[i].w1);
         run_frame(build_frame(tbl[i].n, w, tbl[i].bad_cs), tbl[i].mode, r);
         if (tbl[i].n > SIZE) w.delete();
         check_frame($sformatf("vec%0d", i), r, w, tbl[i].exp_err, tbl[i].exp_words, tbl[i].exp_done);
      end
      check("csum.mem0", mem[0], 32'h08040201);

      // Reset asserted with 6 of 8 payload bytes in: outputs clear at once, then a clean reload.
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      fb = build_frame(2, gen_words(2, 32'hA1B2C3D4, 32'h11223344), 1'b0);
      for (int i = 0; i < 8; i++) push_byte(fb[i]);
      check("rst.hold_pre", 32'(bus.cpu_hold), 32'd1);
      check("rst.words_pre", 32'(bus.words), 32'd1);
      check("rst.wd_pre", bus.wd, 32'hA1B2C3D4);
      #2 rst_n = 1'b0;
      #1;
      check_reset_vals("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      w = gen_words(2, 32'h76543210, 32'hFEDCBA98);
      run_frame(build_frame(2, w, 1'b0), 0, r);
      check_frame("reload", r, w, 1'b0, 2, 13 + CS);

      // Random frames: expectations follow the frame rules directly.
      for (int t = 0; t < 14; t++) begin
         int      n;
         bit      bcs;
         logic    e;
         word_q_t rw;
         word_q_t ew;
         case ($urandom_range(0, 3))
            0:       n = $urandom_range(0, 3);
            1:       n = $urandom_range(4, 20);
            2:       n = $urandom_range(62, 66);
            default: n = $urandom_range(0, 70);
         endcase
         rw.delete();
         for (int i = 0; i < n; i++) rw.push_back($urandom);
         bcs = ($urandom_range(0, 3) == 0);
         ew.delete();
         if (n <= SIZE) ew = rw;
         e = (n > SIZE) || (CS == 1 && bcs);
         run_frame(build_frame(n, rw, bcs), 2, r);
         check_frame($sformatf("rnd%0d", t), r, ew, e, (n <= SIZE) ? n : 0, -1);
      end

      $display("test done: total=%0d bad=%0d", total, nbad);
      $finish;
   end

endmodule
